// File: rtl/mmio_io_responder_if.sv
// Processor data-bus port for the MMIO responder: word address, store data,
// load/store strobes and the registered load return.
interface mmio_io_responder_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic        re;
  logic [15:0] rdata;
  logic        rdata_vld;

  modport master (
    output addr, wdata, we, re,
    input  rdata, rdata_vld
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, rdata_vld
  );
endinterface

// File: rtl/mmio_io_responder.sv
// MMIO responder at BASE_ADDR: LED register, synchronized and debounced switch
// input, sticky change flag with interrupt enable, and a 16-bit change counter.
module mmio_io_responder #(
  parameter logic [15:0] BASE_ADDR       = 16'hC000,
  parameter int          NUM_SW          = 10,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  mmio_io_responder_if.slave  bus,
  input  logic [NUM_SW-1:0]   SW_in,
  output logic [NUM_SW-1:0]   LEDR_out,
  output logic                irq
);

  typedef enum logic [1:0] {
    REG_LED    = 2'd0,
    REG_SW     = 2'd1,
    REG_STATUS = 2'd2,
    REG_CHGCNT = 2'd3
  } reg_sel_e;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] led_reg;
  logic [NUM_SW-1:0] sync_meta;
  logic [NUM_SW-1:0] sw_sync;
  logic [NUM_SW-1:0] candidate;
  logic [NUM_SW-1:0] debounced;
  logic [15:0]       db_cnt;
  logic              chg_flag;
  logic              ie;
  logic [15:0]       chg_cnt;

  logic [15:0] offset;
  logic        hit;
  reg_sel_e    reg_sel;
  logic        rd_hit;
  logic        wr_hit;
  logic        chg_event;
  logic [15:0] rd_mux;
  logic        wdata_unused;

  // Subtraction wraps, so a single unsigned compare covers both range ends.
  assign offset  = bus.addr - BASE_ADDR;
  assign hit     = (offset < 16'd4);
  assign reg_sel = reg_sel_e'(offset[1:0]);
  assign rd_hit  = bus.re & hit;
  assign wr_hit  = bus.we & hit;

  assign wdata_unused = &{1'b0, bus.wdata};

  // The debounced value moves on this edge, and only to a different value.
  assign chg_event = (sw_sync == candidate) && (candidate != debounced) &&
                     (db_cnt == DB_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sw_sync   <= '0;
      candidate <= '0;
      debounced <= '0;
      db_cnt    <= '0;
    end else begin
      sync_meta <= SW_in;
      sw_sync   <= sync_meta;
      if (sw_sync != candidate) begin
        candidate <= sw_sync;
        db_cnt    <= '0;
      end else if (candidate != debounced) begin
        if (db_cnt == DB_LAST) begin
          debounced <= candidate;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    unique case (reg_sel)
      REG_LED:    rd_mux[NUM_SW-1:0] = led_reg;
      REG_SW:     rd_mux[NUM_SW-1:0] = debounced;
      REG_STATUS: rd_mux[1:0]        = {ie, chg_flag};
      REG_CHGCNT: rd_mux             = chg_cnt;
      default:    rd_mux             = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg   <= '0;
      chg_flag  <= 1'b0;
      ie        <= 1'b0;
      chg_cnt   <= '0;
      bus.rdata <= '0;
      bus.rdata_vld <= 1'b0;
    end else begin
      if (wr_hit && reg_sel == REG_LED) led_reg <= bus.wdata[NUM_SW-1:0];
      if (wr_hit && reg_sel == REG_STATUS) ie <= bus.wdata[1];

      // A new change outranks the clear-on-read of STATUS.
      if (chg_event) chg_flag <= 1'b1;
      else if (rd_hit && reg_sel == REG_STATUS) chg_flag <= 1'b0;

      // Clear-then-count: a CHGCNT write on a change edge leaves 1.
      if (wr_hit && reg_sel == REG_CHGCNT) chg_cnt <= {15'd0, chg_event};
      else if (chg_event) chg_cnt <= chg_cnt + 16'd1;

      bus.rdata_vld <= rd_hit;
      bus.rdata     <= rd_hit ? rd_mux : 16'd0;
    end
  end

  assign LEDR_out = led_reg;
  assign irq      = chg_flag & ie;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Randomized and directed bench for mmio_io_responder, compared every cycle
// against a window-based behavioural model of the register file and debouncer.
module tb_mmio_io_responder;

  localparam logic [15:0] BASE   = 16'hC000;
  localparam int          NSW    = 10;
  localparam int          DB     = 4;

  logic            stim_clk = 1'b0;
  logic            rst      = 1'b1;
  logic [NSW-1:0]  sw_in    = '0;
  logic [NSW-1:0]  ledr_out;
  logic            irq;

  mmio_io_responder_if bus_if ();

  mmio_io_responder #(
    .BASE_ADDR(BASE), .NUM_SW(NSW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (stim_clk),
    .rst      (rst),
    .bus      (bus_if),
    .SW_in    (sw_in),
    .LEDR_out (ledr_out),
    .irq      (irq)
  );

  always #5 stim_clk = ~stim_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state as seen after the most recent clock edge.
  logic [NSW-1:0] m_led, m_deb;
  logic           m_flag, m_ie, m_vld;
  logic [15:0]    m_cnt, m_rdata;
  logic [NSW-1:0] sw_hist[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_deb = '0; m_flag = 1'b0; m_ie = 1'b0;
    m_cnt = '0; m_rdata = '0; m_vld = 1'b0;
    sw_hist.delete();
    for (int k = 0; k < DB + 3; k++) sw_hist.push_back('0);
  endtask

  // Debounced value takes v once the DB+1 samples that have cleared the
  // two-flop synchronizer all equal v.
  task automatic model_edge();
    int             a, last;
    bit             hit, same, chg;
    logic [1:0]     off;
    logic [NSW-1:0] win;
    logic [15:0]    rv;
    if (rst) begin
      model_reset();
      return;
    end
    sw_hist.push_back(sw_in);
    if (sw_hist.size() > DB + 4) void'(sw_hist.pop_front());
    last = sw_hist.size() - 3;
    win  = sw_hist[last];
    same = 1'b1;
    for (int k = last - DB; k <= last; k++) if (sw_hist[k] != win) same = 1'b0;
    chg = same && (win != m_deb);

    a   = int'(bus_if.addr);
    hit = (a >= int'(BASE)) && (a <= int'(BASE) + 3);
    off = 2'(a - int'(BASE));

    rv = 16'd0;
    case (off)
      2'd0: rv = 16'(m_led);
      2'd1: rv = 16'(m_deb);
      2'd2: rv = {14'd0, m_ie, m_flag};
      default: rv = m_cnt;
    endcase
    m_vld   = hit && bus_if.re;
    m_rdata = m_vld ? rv : 16'd0;

    if (hit && bus_if.re && off == 2'd2) m_flag = 1'b0;
    if (chg) m_flag = 1'b1;
    if (hit && bus_if.we && off == 2'd0) m_led = bus_if.wdata[NSW-1:0];
    if (hit && bus_if.we && off == 2'd2) m_ie = bus_if.wdata[1];
    if (hit && bus_if.we && off == 2'd3) m_cnt = 16'd0;
    if (chg) m_cnt = m_cnt + 16'd1;
    if (chg) m_deb = win;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".led"},  16'(ledr_out), 16'(m_led));
    check_eq({tag, ".irq"},  16'(irq), 16'(m_flag & m_ie));
    check_eq({tag, ".vld"},  16'(bus_if.rdata_vld), 16'(m_vld));
    check_eq({tag, ".rdata"}, bus_if.rdata, m_rdata);
  endtask

  // Inputs are already driven; advance one edge and compare on the falling edge.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge stim_clk);
    @(negedge stim_clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    bus_if.we = 1'b0; bus_if.re = 1'b0;
    for (int k = 0; k < n; k++) cycle("idle");
  endtask

  task automatic bus_read(input logic [15:0] a, input string tag);
    bus_if.addr = a; bus_if.re = 1'b1; bus_if.we = 1'b0;
    cycle(tag);
    bus_if.re = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input string tag);
    bus_if.addr = a; bus_if.wdata = d; bus_if.we = 1'b1; bus_if.re = 1'b0;
    cycle(tag);
    bus_if.we = 1'b0;
  endtask

  initial begin
    int hold_left;
    bus_if.addr = '0; bus_if.wdata = '0; bus_if.we = 1'b0; bus_if.re = 1'b0;
    model_reset();

    // Reset state, then every register reads zero.
    repeat (2) @(negedge stim_clk);
    check_outputs("reset");
    rst = 1'b0;
    for (int r = 0; r < 4; r++) bus_read(BASE + 16'(r), "rd_after_reset");
    idle(1);

    // LED stores and readback; SW ignores writes.
    bus_write(BASE, 16'h0001, "led_wr1");
    bus_write(BASE, 16'h0002, "led_wr2");
    bus_read(BASE, "led_rd");
    bus_write(BASE + 16'd1, 16'h1234, "sw_wr");
    bus_read(BASE + 16'd1, "sw_rd_unchanged");

    // Stable switch change, status clear-on-read, change count.
    sw_in = 10'h003;
    idle(9);
    bus_read(BASE + 16'd1, "sw_rd_3");
    bus_read(BASE + 16'd2, "status_rd1");
    bus_read(BASE + 16'd2, "status_rd2");
    bus_read(BASE + 16'd3, "chgcnt_rd1");

    // Return to zero, then a 3-cycle glitch must not register.
    sw_in = 10'h000;
    idle(9);
    bus_read(BASE + 16'd2, "status_clr");
    sw_in = 10'h001;
    idle(3);
    sw_in = 10'h000;
    idle(10);
    bus_read(BASE + 16'd1, "glitch_sw");
    bus_read(BASE + 16'd2, "glitch_status");
    bus_read(BASE + 16'd3, "glitch_cnt");

    // Interrupt enable, irq on change, read clears, concurrent change holds it.
    bus_write(BASE + 16'd2, 16'h0002, "ie_wr");
    sw_in = 10'h2AA;
    idle(9);
    bus_read(BASE + 16'd2, "irq_clear_rd");
    idle(1);
    sw_in = 10'h155;
    idle(6);
    bus_read(BASE + 16'd2, "status_rd_on_change");
    check_eq("irq_set_wins", 16'(irq), 16'd1);
    bus_read(BASE + 16'd2, "status_rd_after");

    // Counter wrap from 0xFFFF.
    force dut.chg_cnt = 16'hFFFF;
    #1 release dut.chg_cnt;
    m_cnt = 16'hFFFF;
    sw_in = 10'h0F0;
    idle(9);
    bus_read(BASE + 16'd3, "chgcnt_wrap");
    check_eq("chgcnt_wrap_zero", bus_if.rdata, 16'h0000);

    // CHGCNT write coinciding with a change leaves 1.
    sw_in = 10'h00F;
    idle(6);
    bus_write(BASE + 16'd3, 16'hFFFF, "chgcnt_clr_on_change");
    bus_read(BASE + 16'd3, "chgcnt_after_clr");
    check_eq("chgcnt_clear_then_count", bus_if.rdata, 16'h0001);

    // Misses on either side of the window do nothing.
    bus_write(BASE + 16'd4, 16'h03FF, "miss_wr_hi");
    bus_read(BASE + 16'd4, "miss_rd_hi");
    bus_write(BASE - 16'd1, 16'h03FF, "miss_wr_lo");
    bus_read(BASE - 16'd1, "miss_rd_lo");
    bus_read(BASE, "led_after_miss");

    // Reset landing mid-read and mid-debounce.
    sw_in = 10'h3C3;
    idle(2);
    bus_if.addr = BASE + 16'd3; bus_if.re = 1'b1;
    @(posedge stim_clk);
    #1 rst = 1'b1;
    #1 check_eq("abort_rd_vld", 16'(bus_if.rdata_vld), 16'd0);
    check_eq("abort_rd_data", bus_if.rdata, 16'd0);
    model_reset();
    bus_if.re = 1'b0;
    @(negedge stim_clk);
    check_outputs("in_reset");
    cycle("in_reset2");
    rst = 1'b0;
    idle(10);
    bus_read(BASE + 16'd1, "sw_after_reset");

    // Randomized traffic with mixed glitches and stable switch values.
    hold_left = 0;
    for (int t = 0; t < 4000; t++) begin
      if (hold_left == 0) begin
        sw_in     = NSW'($urandom);
        hold_left = $urandom_range(12, 1);
      end
      hold_left--;
      bus_if.addr  = BASE - 16'd1 + 16'($urandom_range(6, 0));
      bus_if.wdata = 16'($urandom);
      bus_if.we    = ($urandom_range(3, 0) == 0);
      bus_if.re    = ($urandom_range(2, 0) == 0);
      cycle("rand");
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
